// File: rtl/mips_pkg.sv
// Shared MIPS-style encodings: ALU opCodes, aluOp classes, funct fields and the
// ID/EX control bundle.
package mips_pkg;

    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned OPC_W   = 4;

    // Register zero is hard-wired; never a forwarding or hazard source.
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_AND     = 4'b0000,
        OP_OR      = 4'b0001,
        OP_ADD     = 4'b0010,
        OP_SLL     = 4'b0011,
        OP_SRL     = 4'b0100,
        OP_SUB     = 4'b0110,
        OP_SLT     = 4'b0111,
        OP_NOR     = 4'b1100,
        OP_INVALID = 4'b1111
    } alu_op_e;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 2'b11;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'b000000;
    localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'b000010;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
    } ex_ctrl_t;

    // Translate the decoder's aluOp/funct pair into the ALU opCode.
    function automatic alu_op_e alu_decode(input logic [ALUOP_W-1:0] alu_op,
                                           input logic [FUNCT_W-1:0] funct);
        alu_op_e op;
        op = OP_INVALID;
        case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_OR:  op = OP_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: op = OP_ADD;
                    FUNCT_SUB: op = OP_SUB;
                    FUNCT_AND: op = OP_AND;
                    FUNCT_OR:  op = OP_OR;
                    FUNCT_NOR: op = OP_NOR;
                    FUNCT_SLT: op = OP_SLT;
                    FUNCT_SLL: op = OP_SLL;
                    FUNCT_SRL: op = OP_SRL;
                    default:   op = OP_INVALID;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result beats MEM/WB data beats the
// register-file value; register zero never forwards.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic [RADDR-1:0] reg_i,
    input  logic [WIDTH-1:0] reg_data_i,
    input  logic             ex_we_i,
    input  logic [RADDR-1:0] ex_rd_i,
    input  logic [WIDTH-1:0] ex_data_i,
    input  logic             wb_we_i,
    input  logic [RADDR-1:0] wb_rd_i,
    input  logic [WIDTH-1:0] wb_data_i,
    output logic [WIDTH-1:0] data_o
);

    logic reg_nonzero;

    assign reg_nonzero = (reg_i != RADDR'(REG_ZERO));

    always_comb begin
        data_o = reg_data_i;
        if (reg_nonzero && ex_we_i && (ex_rd_i == reg_i)) begin
            data_o = ex_data_i;
        end else if (reg_nonzero && wb_we_i && (wb_rd_i == reg_i)) begin
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: registers decode results, forwards
// from EX/MEM and MEM/WB, and inserts a single bubble on a load-use hazard.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               idValid,
    input  logic [WIDTH-1:0]   idRsData,
    input  logic [WIDTH-1:0]   idRtData,
    input  logic [WIDTH-1:0]   idImm,
    input  logic [RADDR-1:0]   idRs,
    input  logic [RADDR-1:0]   idRt,
    input  logic [RADDR-1:0]   idRd,
    input  logic [4:0]         idShamt,
    input  logic [5:0]         idFunct,
    input  logic [1:0]         idAluOp,
    input  logic               idAluSrc,
    input  logic               idRegDst,
    input  logic               idRegWrite,
    input  logic               idMemRead,
    input  logic               idMemWrite,
    input  logic               idMemToReg,
    input  logic               stall,
    input  logic               flush,
    input  logic               exMemRegWrite,
    input  logic [RADDR-1:0]   exMemRd,
    input  logic [WIDTH-1:0]   exMemResult,
    input  logic               memWbRegWrite,
    input  logic [RADDR-1:0]   memWbRd,
    input  logic [WIDTH-1:0]   memWbData,
    output logic [WIDTH-1:0]   in1,
    output logic [WIDTH-1:0]   in2,
    output logic [3:0]         opCode,
    output logic [4:0]         shiftAmt,
    output logic               exValid,
    output logic [WIDTH-1:0]   exRtData,
    output logic [RADDR-1:0]   exWriteReg,
    output logic               exRegWrite,
    output logic               exMemRead,
    output logic               exMemWrite,
    output logic               exMemToReg,
    output logic               hazardStall,
    output logic               illegal
);

    ex_ctrl_t          ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  rs_data_q, rs_data_d;
    logic [WIDTH-1:0]  rt_data_q, rt_data_d;
    logic [WIDTH-1:0]  imm_q, imm_d;
    logic [RADDR-1:0]  rs_q, rs_d;
    logic [RADDR-1:0]  rt_q, rt_d;
    logic [RADDR-1:0]  wreg_q, wreg_d;
    logic [4:0]        shamt_q, shamt_d;

    logic [WIDTH-1:0]  fwd_rs;
    logic [WIDTH-1:0]  fwd_rt;
    logic              is_shift;

    // Load in EX whose destination is read by the instruction in decode.
    assign hazardStall = ctrl_q.valid && ctrl_q.mem_read && idValid
                         && (wreg_q != RADDR'(REG_ZERO))
                         && ((wreg_q == idRs) || (wreg_q == idRt));

    // Next-state: stall holds, flush/hazard loads a bubble, otherwise capture.
    always_comb begin
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        wreg_d    = wreg_q;
        shamt_d   = shamt_q;
        if (stall) begin
            ctrl_d = ctrl_q;
        end else if (flush || hazardStall) begin
            ctrl_d    = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            wreg_d    = '0;
            shamt_d   = '0;
        end else begin
            ctrl_d.valid      = idValid;
            ctrl_d.op         = alu_decode(idAluOp, idFunct);
            ctrl_d.alu_src    = idAluSrc;
            ctrl_d.reg_write  = idRegWrite;
            ctrl_d.mem_read   = idMemRead;
            ctrl_d.mem_write  = idMemWrite;
            ctrl_d.mem_to_reg = idMemToReg;
            rs_data_d         = idRsData;
            rt_data_d         = idRtData;
            imm_d             = idImm;
            rs_d              = idRs;
            rt_d              = idRt;
            wreg_d            = idRegDst ? idRd : idRt;
            shamt_d           = idShamt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            wreg_q    <= '0;
            shamt_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            wreg_q    <= wreg_d;
            shamt_q   <= shamt_d;
        end
    end

    fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs (
        .reg_i      (rs_q),
        .reg_data_i (rs_data_q),
        .ex_we_i    (exMemRegWrite),
        .ex_rd_i    (exMemRd),
        .ex_data_i  (exMemResult),
        .wb_we_i    (memWbRegWrite),
        .wb_rd_i    (memWbRd),
        .wb_data_i  (memWbData),
        .data_o     (fwd_rs)
    );

    fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rt (
        .reg_i      (rt_q),
        .reg_data_i (rt_data_q),
        .ex_we_i    (exMemRegWrite),
        .ex_rd_i    (exMemRd),
        .ex_data_i  (exMemResult),
        .wb_we_i    (memWbRegWrite),
        .wb_rd_i    (memWbRd),
        .wb_data_i  (memWbData),
        .data_o     (fwd_rt)
    );

    // Shifts take their operand from rt and the amount from the shamt field.
    assign is_shift = (ctrl_q.op == OP_SLL) || (ctrl_q.op == OP_SRL);

    assign in1      = is_shift ? fwd_rt : fwd_rs;
    assign in2      = is_shift ? '0 : (ctrl_q.alu_src ? imm_q : fwd_rt);
    assign shiftAmt = is_shift ? shamt_q : 5'd0;
    assign opCode   = ctrl_q.op;
    assign exRtData = fwd_rt;

    assign exValid    = ctrl_q.valid;
    assign exWriteReg = wreg_q;
    assign exRegWrite = ctrl_q.valid && ctrl_q.reg_write;
    assign exMemRead  = ctrl_q.valid && ctrl_q.mem_read;
    assign exMemWrite = ctrl_q.valid && ctrl_q.mem_write;
    assign exMemToReg = ctrl_q.valid && ctrl_q.mem_to_reg;
    assign illegal    = ctrl_q.valid && (ctrl_q.op == OP_INVALID);

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU.
- Registers decoded operands and control, and translates aluOp/funct into the ALU's 4-bit opCode.
- Applies EX/MEM and MEM/WB forwarding to produce the ALU's in1/in2/shiftAmt.
- Detects load-use hazards and inserts one bubble.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register-number width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- idValid  in  1  decode slot holds a real instruction
- idRsData, idRtData, idImm  in  WIDTH each  register-file reads; sign-extended immediate
- idRs, idRt, idRd  in  RADDR each  register numbers
- idShamt  in  5  shift amount field
- idFunct  in  6  funct field
- idAluOp  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or
- idAluSrc, idRegDst, idRegWrite, idMemRead, idMemWrite, idMemToReg  in  1 each  decode controls
- stall  in  1  hold stage contents (downstream busy)
- flush  in  1  squash stage contents (branch/jump taken)
- exMemRegWrite  in  1;  exMemRd  in  RADDR;  exMemResult  in  WIDTH  — EX/MEM forward source
- memWbRegWrite  in  1;  memWbRd  in  RADDR;  memWbData  in  WIDTH  — MEM/WB forward source
- in1, in2  out  WIDTH  ALU operands
- opCode  out  4  ALU operation
- shiftAmt  out  5  ALU shift amount
- exValid  out  1  stage holds a real instruction
- exRtData  out  WIDTH  forwarded rt, used as store data
- exWriteReg  out  RADDR  destination register (rd if regDst, else rt)
- exRegWrite, exMemRead, exMemWrite, exMemToReg  out  1 each  registered controls, gated by valid
- hazardStall  out  1  load-use detected; upstream must hold PC and IF/ID
- illegal  out  1  valid R-type instruction with unsupported funct

Behaviour:
- Reset (synchronous, active-high):
  - All stage registers clear; exValid = 0.
  - Every control output = 0.
  - opCode = 4'b0000, in1 = in2 = 0, shiftAmt = 0.
- opCode encoding (shared with ALU):
  - AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, NOR 1100, INVALID 1111.
- Decode is done at capture time and the opCode is registered:
  - aluOp 00 → ADD; 01 → SUB; 11 → OR.
  - aluOp 10 uses funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL.
  - Any other funct → INVALID, and illegal = 1 while exValid.
- Update priority each edge: reset > stall (hold everything) > flush or hazard (capture bubble) > normal capture.
  - A bubble is exValid = 0 with all registered controls = 0.
- Load-use hazard:
  - hazardStall = exValid & exMemRead & idValid & (exWriteReg != 0) & (exWriteReg == idRs | exWriteReg == idRt).
  - It is combinational and independent of flush.
  - Exactly one bubble is inserted, because the next cycle's exMemRead is 0.
- External stall: hazardStall must not advance anything; the stage holds as it does for any stall.
- Forwarding (combinational on registered rs/rt):
  - EX/MEM match takes priority over MEM/WB.
  - A match requires regWrite = 1 and Rd == reg and reg != 0.
  - Otherwise the registered read data is used.
- Operand select:
  - If opCode is SLL or SRL: in1 = fwdRt, in2 = 0, shiftAmt = registered shamt.
  - Else: in1 = fwdRs, in2 = aluSrc ? imm : fwdRt, shiftAmt = 0.
- exRtData = fwdRt at all times.
- Controls are AND-gated with exValid, so no write or memory side effect ever comes from a bubble.
- Latency: one cycle from decode inputs to registered outputs.
  - Forwarded operands reflect the same-cycle EX/MEM and MEM/WB values.

Decomposition:
- Shared package mips_pkg holds:
  - the opCode constants (shared with the ALU);
  - the aluOp codes;
  - the funct constants;
  - the register-zero constant.
- One natural sub-module: fwd_mux. It takes a register number plus both forward sources and returns the selected value. It is instantiated twice, for rs and rt.

Test Plan:
- Reset mid-stream: load `add` (funct 100000), assert reset one cycle → exValid = 0, opCode = 0000, exRegWrite = 0, in1 = in2 = 0.
- R-type decode:
  - idFunct = 100111, aluOp 10 → opCode = 1100.
  - idFunct = 000010, shamt 4, rt = 16 → in1 = 16, shiftAmt = 4, opCode = 0100.
  - idFunct = 111111 → illegal = 1.
- Forwarding: stage rs = 3. Set exMemRd = 3 (0xAAAA) and memWbRd = 3 (0x5555), both regWrite → in1 = 0xAAAA. Drop exMemRegWrite → in1 = 0x5555. With rs = 0 → in1 = registered data.
- Load-use: lw writing r5 in EX, decode rs = 5 → hazardStall = 1 for exactly one cycle, next cycle exValid = 0; after the bubble → hazardStall = 0 and the dependent instruction is captured.
- Stall versus flush:
  - stall = 1 and flush = 1 together → contents held unchanged.
  - flush alone → exValid = 0 and exMemWrite = 0 next cycle.
- aluSrc: addi with imm = -7, rs data = 5, aluOp 00 → in2 = 0xFFFFFFF9, opCode = 0010.
